// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port RAM arbiter: FSM state encoding and port identifiers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    localparam logic P_CORE = 1'b0;
    localparam logic P_DBG  = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to the port
// that was not granted last.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       sel,
    output logic       valid
);

    always_comb begin
        valid = |req;
        if (req == 2'b11) begin
            sel = ~last;
        end else begin
            sel = req[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the core (port 0) and the debug loader (port 1):
// round-robin, one outstanding access, fixed read latency, all outputs registered.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic [DATA_W/8-1:0] m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic [DATA_W/8-1:0] m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_t state, state_next;
    logic sel_q, sel_d;
    logic last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic pick_sel, pick_valid;

    logic mem_en_d;
    logic [STRB_W-1:0] mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic m0_gnt_d, m1_gnt_d, m0_rvalid_d, m1_rvalid_d;
    logic [DATA_W-1:0] m0_rdata_d, m1_rdata_d;

    rr_arbiter2 u_pick (
        .req   ({m1_req, m0_req}),
        .last  (last_q),
        .sel   (pick_sel),
        .valid (pick_valid)
    );

    // The mem_* output registers double as the command capture registers: they are
    // loaded on the IDLE->ISSUE edge and are therefore valid exactly in the ISSUE cycle.
    always_comb begin
        state_next  = state;
        sel_d       = sel_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = '0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        m0_gnt_d    = 1'b0;
        m1_gnt_d    = 1'b0;
        m0_rvalid_d = 1'b0;
        m1_rvalid_d = 1'b0;
        m0_rdata_d  = m0_rdata;
        m1_rdata_d  = m1_rdata;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next  = ISSUE;
                    sel_d       = pick_sel;
                    last_d      = pick_sel;
                    mem_en_d    = 1'b1;
                    mem_we_d    = pick_sel ? m1_we    : m0_we;
                    mem_addr_d  = pick_sel ? m1_addr  : m0_addr;
                    mem_wdata_d = pick_sel ? m1_wdata : m0_wdata;
                    m0_gnt_d    = (pick_sel == P_CORE);
                    m1_gnt_d    = (pick_sel == P_DBG);
                end
            end
            ISSUE: begin
                if (mem_we != '0) begin
                    state_next = IDLE;
                end else begin
                    state_next = WAIT;
                    cnt_d      = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_next = RESP;
                    if (sel_q == P_DBG) begin
                        m1_rdata_d = mem_rdata;
                    end else begin
                        m0_rdata_d = mem_rdata;
                    end
                    m0_rvalid_d = (sel_q == P_CORE);
                    m1_rvalid_d = (sel_q == P_DBG);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset abandons any transaction in flight; the pointer starts at port 1 so port 0
    // wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel_q     <= P_CORE;
            last_q    <= P_DBG;
            cnt_q     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            state     <= state_next;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            m0_gnt    <= m0_gnt_d;
            m1_gnt    <= m1_gnt_d;
            m0_rvalid <= m0_rvalid_d;
            m1_rvalid <= m1_rvalid_d;
            m0_rdata  <= m0_rdata_d;
            m1_rdata  <= m1_rdata_d;
        end
    end

endmodule
